// File: rtl/fmul_sched_if.sv
// Request/response channels between the FP operand sources, the result
// consumer and the multiplier scheduler.
interface fmul_sched_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_data;

  // Requesters and the result consumer drive this side.
  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data
  );

  // The scheduler drives this side.
  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/fmul_sched.sv
// Round-robin scheduler sharing one iterative FP multiplier core between two
// requesters; one operation in flight, fixed wait on the core latency.
module fmul_sched #(
  parameter int MUL_LAT = 26,
  parameter int CNT_W   = 6
) (
  input  logic         clk,
  input  logic         res,
  fmul_sched_if.slave  bus,
  output logic         mul_res,
  output logic [31:0]  mul_a,
  output logic [31:0]  mul_b,
  input  logic [31:0]  mul_out,
  output logic         busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [1:0]       state;
  logic             last_grant;
  logic             cur_id;
  logic [CNT_W-1:0] wait_cnt;
  logic             idle;
  logic             grant0;
  logic             grant1;

  // last_grant names the requester served most recently; the other one wins a tie.
  assign idle   = (state == ST_IDLE);
  assign grant0 = idle & bus.req0_valid & (~bus.req1_valid | last_grant);
  assign grant1 = idle & bus.req1_valid & (~bus.req0_valid | ~last_grant);

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign mul_res        = res | (state == ST_ISSUE);
  assign busy           = ~idle;

  // NOTE: every register here is updated with <= so all flops sample the
  // pre-edge values of each other, independent of statement order.
  always_ff @(posedge clk) begin
    if (res) begin
      state         <= ST_IDLE;
      last_grant    <= 1'b1;
      cur_id        <= 1'b0;
      wait_cnt      <= '0;
      mul_a         <= '0;
      mul_b         <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant0) begin
            mul_a      <= bus.req0_a;
            mul_b      <= bus.req0_b;
            cur_id     <= 1'b0;
            last_grant <= 1'b0;
            state      <= ST_ISSUE;
          end else if (grant1) begin
            mul_a      <= bus.req1_a;
            mul_b      <= bus.req1_b;
            cur_id     <= 1'b1;
            last_grant <= 1'b1;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wait_cnt <= CNT_W'(MUL_LAT - 1);
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          // The core output is only trusted once the full latency has elapsed.
          if (wait_cnt == '0) begin
            bus.rsp_data  <= mul_out;
            bus.rsp_id    <= cur_id;
            bus.rsp_valid <= 1'b1;
            state         <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fmul_sched.sv
// Self-checking bench for fmul_sched: directed scenarios plus randomized
// traffic, checked every cycle against a transaction-level reference model.
module tb_fmul_sched;
  localparam int MUL_LAT = 26;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        res = 1'b1;
  logic        mul_res;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [31:0] mul_out;
  logic        busy;
  logic [5:0]  core_cnt;

  fmul_sched_if bus();

  fmul_sched #(.MUL_LAT(MUL_LAT), .CNT_W(6)) dut (
    .clk     (clk),
    .res     (res),
    .bus     (bus),
    .mul_res (mul_res),
    .mul_a   (mul_a),
    .mul_b   (mul_b),
    .mul_out (mul_out),
    .busy    (busy)
  );

  // Plain IEEE-754 single multiply for normal operands, truncating rounding.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          e;
    logic [47:0] m;
    logic [22:0] f;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    m = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (m[47]) begin
      f = m[46:24];
      e = e + 1;
    end else begin
      f = m[45:23];
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    return {s, 8'(e), f};
  endfunction

  // Core stand-in: garbage while restarting, product appears at the last
  // cycle the scheduler is allowed to sample it.
  always @(posedge clk) begin
    if (mul_res) begin
      core_cnt <= 6'd0;
      mul_out  <= 32'hFFFF_FFFF;
    end else begin
      if (core_cnt == 6'(MUL_LAT - 2)) mul_out <= fmul(mul_a, mul_b);
      if (core_cnt != 6'd63) core_cnt <= core_cnt + 6'd1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model state
  int          cyc = 0;
  bit          m_busy = 0;
  int          m_acc_cyc = 0;
  bit          m_id = 0;
  bit          m_last = 1;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  logic [31:0] m_data = '0;
  int          n_acc = 0;
  int          n_rsp = 0;
  int          n_dropped = 0;
  int          hs_cyc = 0;
  bit          keep_valid = 0;
  bit          prev_rv = 0;
  bit          e_r0, e_r1, e_rv, acc0, acc1;
  int          acc_log[$];
  bit          id_log[$];
  int          rise_log[$];
  logic [31:0] rsp_data_log[$];
  bit          rsp_id_log[$];

  task automatic step();
    logic [31:0] a, b;
    bit          id;
    @(negedge clk);
    e_r0 = !m_busy && bus.req0_valid && (!bus.req1_valid || m_last);
    e_r1 = !m_busy && bus.req1_valid && (!bus.req0_valid || !m_last);
    e_rv = m_busy && (cyc >= m_acc_cyc + MUL_LAT + 2);
    if (bus.rsp_valid && !prev_rv) rise_log.push_back(cyc);
    prev_rv = bus.rsp_valid;
    if (res) begin
      check("mul_res_in_reset", mul_res, 1);
    end else begin
      check("req0_ready", bus.req0_ready, e_r0);
      check("req1_ready", bus.req1_ready, e_r1);
      check("busy", busy, m_busy);
      check("mul_res", mul_res, m_busy && (cyc == m_acc_cyc + 1));
      check("rsp_valid", bus.rsp_valid, e_rv);
      check("mul_a", mul_a, m_a);
      check("mul_b", mul_b, m_b);
      if (e_rv) begin
        check("rsp_id", bus.rsp_id, m_id);
        check("rsp_data", bus.rsp_data, m_data);
        if (bus.rsp_ready) begin
          rsp_data_log.push_back(bus.rsp_data);
          rsp_id_log.push_back(bus.rsp_id);
        end
      end
    end
    @(posedge clk);
    acc0 = 0;
    acc1 = 0;
    if (res) begin
      if (m_busy) n_dropped++;
      m_busy = 0;
      m_last = 1;
      m_a    = '0;
      m_b    = '0;
    end else if (e_r0 || e_r1) begin
      id        = e_r1;
      a         = id ? bus.req1_a : bus.req0_a;
      b         = id ? bus.req1_b : bus.req0_b;
      m_busy    = 1;
      m_acc_cyc = cyc;
      m_id      = id;
      m_last    = id;
      m_a       = a;
      m_b       = b;
      m_data    = fmul(a, b);
      acc_log.push_back(cyc);
      id_log.push_back(id);
      n_acc++;
      acc0 = e_r0;
      acc1 = e_r1;
    end else if (e_rv && bus.rsp_ready) begin
      m_busy = 0;
      n_rsp++;
      hs_cyc = cyc;
    end
    cyc++;
    #1;
    if (!keep_valid) begin
      if (acc0) bus.req0_valid = 1'b0;
      if (acc1) bus.req1_valid = 1'b0;
    end
  endtask

  task automatic run_until_acc(input int target, input int budget, input string tag);
    for (int i = 0; i < budget && n_acc < target; i++) step();
    check(tag, n_acc, target);
  endtask

  task automatic run_until_rsp(input int target, input int budget, input string tag);
    for (int i = 0; i < budget && n_rsp < target; i++) step();
    check(tag, n_rsp, target);
  endtask

  function automatic logic [31:0] rnd_flt();
    return {1'($urandom_range(1)), 8'($urandom_range(154, 100)), 23'($urandom)};
  endfunction

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, base, r0, nb;
    bus.req0_valid = 0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 0; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp_ready  = 1;

    // Reset state
    res = 1;
    repeat (2) step();
    res = 0;
    step();
    check("rst_rsp_data", bus.rsp_data, 32'h0);
    check("rst_rsp_id", bus.rsp_id, 0);

    // Single multiply: 2.0 * 3.0
    bus.req0_a = 32'h4000_0000; bus.req0_b = 32'h4040_0000; bus.req0_valid = 1;
    s = cyc;
    run_until_acc(1, 5, "s1_accept");
    check("s1_acc_cycle", acc_log[$], s);
    run_until_rsp(1, 60, "s1_response");
    check("s1_latency", rise_log[$] - acc_log[$], MUL_LAT + 2);
    check("s1_data", rsp_data_log[$], 32'h40C0_0000);
    check("s1_id", rsp_id_log[$], 0);

    // Contention from reset exit
    bus.req0_a = 32'h3FC0_0000; bus.req0_b = 32'h4000_0000; bus.req0_valid = 1;
    bus.req1_a = 32'hC000_0000; bus.req1_b = 32'h4080_0000; bus.req1_valid = 1;
    res = 1;
    repeat (2) step();
    res = 0;
    base = n_rsp;
    run_until_rsp(base + 2, 120, "s2_two_rsp");
    check("s2_first_data", rsp_data_log[base], 32'h4040_0000);
    check("s2_first_id", rsp_id_log[base], 0);
    check("s2_second_data", rsp_data_log[base + 1], 32'hC100_0000);
    check("s2_second_id", rsp_id_log[base + 1], 1);
    keep_valid = 1;
    bus.req0_valid = 1; bus.req1_valid = 1;
    base = n_acc;
    run_until_acc(base + 6, 400, "s2_six_acc");
    keep_valid = 0;
    bus.req0_valid = 0; bus.req1_valid = 0;
    for (int i = base; i < base + 6 && i < id_log.size(); i++)
      check("s2_alternate", id_log[i], !id_log[i - 1]);
    run_until_rsp(n_acc - n_dropped, 60, "s2_drain");

    // Response backpressure
    bus.rsp_ready = 0;
    bus.req0_a = rnd_flt(); bus.req0_b = rnd_flt(); bus.req0_valid = 1;
    r0 = rise_log.size();
    for (int i = 0; i < 60 && rise_log.size() == r0; i++) step();
    check("s3_rsp_seen", rise_log.size(), r0 + 1);
    bus.req0_a = rnd_flt(); bus.req0_b = rnd_flt(); bus.req0_valid = 1;
    bus.req1_a = rnd_flt(); bus.req1_b = rnd_flt(); bus.req1_valid = 1;
    repeat (10) step();
    bus.rsp_ready = 1;
    step();
    step();
    check("s3_accept_after_hs", acc_log[$], hs_cyc + 1);
    check("s3_winner", id_log[$], 1);
    bus.req0_valid = 0; bus.req1_valid = 0;
    run_until_rsp(n_acc - n_dropped, 60, "s3_drain");

    // Reset in the middle of WAIT
    bus.req0_a = 32'h4040_0000; bus.req0_b = 32'h4040_0000; bus.req0_valid = 1;
    run_until_acc(n_acc + 1, 5, "s4_accept");
    for (int i = 0; i < 20 && cyc < acc_log[$] + 11; i++) step();
    res = 1;
    step();
    res = 0;
    nb = rise_log.size();
    repeat (MUL_LAT + 10) step();
    check("s4_no_rsp", rise_log.size(), nb);
    check("s4_no_handshake", n_rsp, n_acc - n_dropped);
    bus.req0_a = 32'h4000_0000; bus.req0_b = 32'h4080_0000; bus.req0_valid = 1;
    s = cyc;
    run_until_acc(n_acc + 1, 5, "s4_reaccept");
    check("s4_acc_cycle", acc_log[$], s);
    run_until_rsp(n_acc - n_dropped, 60, "s4_response");
    check("s4_latency", rise_log[$] - acc_log[$], MUL_LAT + 2);
    check("s4_data", rsp_data_log[$], 32'h4100_0000);

    // Requester 1 alone, back to back
    keep_valid = 1;
    bus.req1_a = 32'h3F80_0000; bus.req1_b = 32'h3F80_0000; bus.req1_valid = 1;
    base = n_acc;
    run_until_acc(base + 3, 200, "s5_three_acc");
    bus.req1_valid = 0;
    keep_valid = 0;
    run_until_rsp(n_acc - n_dropped, 60, "s5_drain");
    for (int i = base + 1; i < base + 3 && i < acc_log.size(); i++)
      check("s5_spacing", acc_log[i] - acc_log[i - 1], MUL_LAT + 3);
    for (int i = base; i < base + 3 && i < id_log.size(); i++)
      check("s5_id", id_log[i], 1);
    check("s5_data", rsp_data_log[$], 32'h3F80_0000);

    // Randomized traffic with random backpressure
    base = n_rsp;
    for (int i = 0; i < 8000 && n_rsp < base + 60; i++) begin
      if (!bus.req0_valid && $urandom_range(2) == 0) begin
        bus.req0_a = rnd_flt(); bus.req0_b = rnd_flt(); bus.req0_valid = 1;
      end
      if (!bus.req1_valid && $urandom_range(2) == 0) begin
        bus.req1_a = rnd_flt(); bus.req1_b = rnd_flt(); bus.req1_valid = 1;
      end
      bus.rsp_ready = 1'($urandom_range(1));
      step();
    end
    check("rand_rsp_count", n_rsp >= base + 60, 1);
    bus.req0_valid = 0; bus.req1_valid = 0; bus.rsp_ready = 1;
    run_until_rsp(n_acc - n_dropped, 60, "rand_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
